// File: rtl/rut_issue_ctrl.sv
`default_nettype none
// rut_issue_ctrl: single-entry issue stage that checks a held instruction against
// the register usage table and requests the destination busy bit on release.
module rut_issue_ctrl #(
  parameter int unsigned REG_NUMBER    = 32,
  parameter int unsigned REG_BITS      = 5,
  parameter int unsigned BYPASS_FINISH = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_BITS-1:0]   in_rs1,
  input  logic [REG_BITS-1:0]   in_rs2,
  input  logic [REG_BITS-1:0]   in_rd,
  input  logic                  in_use_rs1,
  input  logic                  in_use_rs2,
  input  logic                  in_wr_rd,
  input  logic [31:0]           in_payload,
  input  logic                  flush,
  input  logic [REG_NUMBER-1:0] using,
  input  logic [REG_NUMBER-1:0] finish,
  output logic [REG_NUMBER-1:0] setusing,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_BITS-1:0]   out_rs1,
  output logic [REG_BITS-1:0]   out_rs2,
  output logic [REG_BITS-1:0]   out_rd,
  output logic [31:0]           out_payload,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic                  hold_valid_q, hold_valid_d;
  logic [REG_BITS-1:0]   rs1_q, rs2_q, rd_q;
  logic                  use_rs1_q, use_rs2_q, wr_rd_q;
  logic [31:0]           payload_q;
  logic [CNT_W-1:0]      stall_cnt_q;

  logic [REG_NUMBER-1:0] busy_vec;
  logic                  hazard;
  logic [1:0]            state;
  logic                  fire;
  logic                  accept;
  logic                  stall_inc;

  // A register completing this cycle is treated as free when bypass is enabled.
  always_comb begin
    busy_vec = using & ~((BYPASS_FINISH != 0) ? finish : '0);
    busy_vec[0] = 1'b0;
  end

  assign hazard = (use_rs1_q & busy_vec[rs1_q])
                | (use_rs2_q & busy_vec[rs2_q])
                | (wr_rd_q   & busy_vec[rd_q]);

  always_comb begin
    state = ST_EMPTY;
    if (hold_valid_q) state = hazard ? ST_WAIT : ST_READY;
  end

  assign out_valid = (state == ST_READY) & ~flush & ~rst;
  assign fire      = out_valid & out_ready;
  assign in_ready  = ~flush & (~hold_valid_q | fire);
  assign accept    = in_valid & in_ready;
  assign stall_inc = (state == ST_WAIT) & ~flush & ~(&stall_cnt_q);

  always_comb begin
    setusing = '0;
    if (fire && wr_rd_q && (rd_q != '0)) setusing[rd_q] = 1'b1;
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    if (flush)       hold_valid_d = 1'b0;
    else if (accept) hold_valid_d = 1'b1;
    else if (fire)   hold_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      use_rs1_q    <= 1'b0;
      use_rs2_q    <= 1'b0;
      wr_rd_q      <= 1'b0;
      payload_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      if (accept) begin
        rs1_q     <= in_rs1;
        rs2_q     <= in_rs2;
        rd_q      <= in_rd;
        use_rs1_q <= in_use_rs1;
        use_rs2_q <= in_use_rs2;
        wr_rd_q   <= in_wr_rd;
        payload_q <= in_payload;
      end
      if (stall_inc) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_rd      = rd_q;
  assign out_payload = payload_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: doc/rut_issue_ctrl.md
# rut_issue_ctrl

Single-entry issue controller that consumes the register usage table's busy vector and produces its `setusing` pulses. It sits between decode and execute. It holds one decoded instruction and checks its source and destination registers against `using`, with an optional same-cycle bypass from `finish`. It releases the instruction downstream only when the instruction is hazard-free, and marks the instruction's destination busy on the release cycle.

## Interface
Parameters:
- `REG_NUMBER`, 32: architectural register count; width of the scoreboard vectors.
- `REG_BITS`, 5: register index width.
- `BYPASS_FINISH`, 1: when 1, a register whose `finish` bit is high this cycle counts as free.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: a decoded instruction is presented.
- `in_ready`, out, 1: the holding register can accept an instruction this cycle.
- `in_rs1`, `in_rs2`, `in_rd`, in, REG_BITS each: source and destination register indices.
- `in_use_rs1`, `in_use_rs2`, `in_wr_rd`, in, 1 each: the instruction reads rs1 / reads rs2 / writes rd.
- `in_payload`, in, 32: opaque instruction data, carried through unchanged.
- `flush`, in, 1: discard the held instruction.
- `using`, in, REG_NUMBER: busy vector from the usage table.
- `finish`, in, REG_NUMBER: the same completion vector the table receives.
- `setusing`, out, REG_NUMBER: one-hot busy-set request to the table.
- `out_valid`, out, 1: the held instruction is hazard-free and offered downstream.
- `out_ready`, in, 1: downstream accepts.
- `out_rs1`, `out_rs2`, `out_rd`, out, REG_BITS each; `out_payload`, out, 32: the held instruction's fields.
- `stall_cnt`, out, CNT_W: saturating count of hazard-stall cycles.

## Operation
- State is `hold_valid` plus the latched fields. There are three states:
  - EMPTY: `hold_valid`=0.
  - WAIT: held instruction has a hazard.
  - READY: held instruction has no hazard.
- WAIT and READY are decoded each cycle from the hazard term, not stored.
- Register busy test, per register r:
  - `busy(r)` = `using[r]` & ~(`BYPASS_FINISH` & `finish[r]`).
  - Register index 0 is never busy.
- Hazard term, evaluated on the held fields: (`use_rs1` & busy(rs1)) | (`use_rs2` & busy(rs2)) | (`wr_rd` & busy(rd)).
  - The rd term is the write-after-write check.
- `out_valid` = `hold_valid` & ~hazard & ~`flush` (combinational).
- `fire` = `out_valid` & `out_ready`.
- `setusing` = onehot(rd) when `fire` & `wr_rd` & rd≠0; otherwise all zero. At most one bit is ever set.
- `in_ready` = ~`flush` & (~`hold_valid` | `fire`). This is a pipelined accept: a new entry loads on the same cycle the old one fires.
- On `in_valid` & `in_ready`, all fields are latched and `hold_valid` is set.
- If the entry fires with no new input, `hold_valid` clears.
- `flush` clears `hold_valid` and overrides everything else in that cycle:
  - no fire, no `setusing`;
  - the input is not accepted.
- `stall_cnt` increments on every cycle with `hold_valid` & hazard & ~`flush`, and saturates at all-ones.
- `out_*` fields show the latched values whenever `hold_valid`=1. They are don't-care otherwise.

## Timing
- Reset (`rst`=1 at a clk edge):
  - `hold_valid`=0 and `stall_cnt`=0.
  - Therefore `out_valid`=0, `setusing`=0, `in_ready`=1 after reset.
  - Latched fields reset to 0.
- Reset overrides flush and input.
- Reset mid-hold drops the instruction and issues no `setusing`.
- Latency: accept at edge N, then `out_valid` can rise in cycle N+1 (zero-wait issue). `setusing` is asserted in the fire cycle only.
- The table registers `setusing`, so `using[rd]` is visible one cycle after fire.
  - A dependent instruction accepted on the fire edge is therefore held in the cycle the bit becomes visible, and it stalls correctly.
  - No extra interlock is required.
- Finish bypass: with `BYPASS_FINISH`=1, a held instruction waiting on r fires in the same cycle `finish[r]`=1.
  - With `BYPASS_FINISH`=0, it fires one cycle later.
- Simultaneous `finish[rd]` and fire for the same rd: the table's set term takes priority over clear, so rd stays busy. This is the required behaviour.
- `out_ready` low with no hazard: the instruction stays held, `out_valid` stays high, and `stall_cnt` does not count.

## Test plan
- Reset: after `rst` is held 2 cycles, `in_ready`=1, `out_valid`=0, `setusing`=0, `stall_cnt`=0.
- Independent issue: `using`=0; accept rd=5 with `wr_rd`=1 at edge N; `out_ready`=1.
  - Required: `out_valid`=1 and `setusing`=0x0000_0020 in cycle N+1, asserted for that cycle only.
- RAW stall plus bypass: `using`=0x0000_0008, held rs1=3, `BYPASS_FINISH`=1, hold 4 cycles, then `finish`=0x0000_0008 for one cycle.
  - Required: fire in that finish cycle, with `stall_cnt`=4.
  - With `BYPASS_FINISH`=0, fire occurs one cycle later and `stall_cnt`=5.
- Register 0 and WAW:
  - rd=0 with `wr_rd`=1 and `using`=0xFFFF_FFFF: instruction issues, `setusing`=0.
  - rd=7 with `using[7]`=1: instruction stalls until `using[7]` clears.
- Back-to-back pipelined accept: `in_valid` continuously high, `out_ready`=1, independent registers.
  - Required: one fire per cycle, `in_ready` constantly 1.
- Flush/backpressure: `out_ready`=0 for 3 cycles (`out_valid` stays 1, no `setusing`), then `flush`=1 together with `out_ready`=1 and `in_valid`=1.
  - Required: no fire, no `setusing`, input not accepted, state EMPTY next cycle.
- Saturation: `CNT_W`=4, stall for 20 cycles → `stall_cnt`=15.
